mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Memory stage directly downstream of the execute stage.
- Consumes the execute result bundle: aluop, computed memory address, store data, destination register, write enable, ALU result, and exception flags.
- Memory ops: drives a single-outstanding req/addr_ok/data_ok data-bus handshake, aligns and extends load data, and stalls the pipeline while busy. Non-memory ops pass straight through.
- Produces a registered bundle for writeback.

Parameters:
ALE_CODE, 10'h009, exception number reported for a misaligned access
PERF_W, 32, width of the performance counters (used only under LSU_PERF_CNT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; kills the op held or accepted this cycle
ex_valid_i  in  1  execute bundle valid
ex_aluop_i  in  8  op code (EXE_*_OP)
ex_mem_addr_i  in  32  effective address
ex_reg2_i  in  32  store data
ex_wd_i  in  5  destination register
ex_wreg_i  in  1  register write enable
ex_wdata_i  in  32  ALU result
ex_excp_i  in  1  upstream exception
ex_excp_num_i  in  10  upstream exception number
stallreq_o  out  1  stall request to pipeline control
data_req_o  out  1  bus request
data_we_o  out  1  store
data_addr_o  out  32  word-aligned address
data_wstrb_o  out  4  byte strobes
data_wdata_o  out  32  lane-replicated store data
data_addr_ok_i  in  1  request accepted
data_data_ok_i  in  1  read data or store acknowledge returned
data_rdata_i  in  32  read data
wb_valid_o  out  1  result valid, one cycle per instruction
wb_wd_o  out  5  destination register
wb_wreg_o  out  1  write enable
wb_wdata_o  out  32  result
wb_excp_o  out  1  exception
wb_excp_num_o  out  10  exception number

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs and op registers zero.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - Accept when ex_valid_i and !flush_i.
  - Non-memory op: registers the wb outputs next cycle (latency 1) with ex_wdata_i passed through.
  - ex_excp_i set: pass the bundle through and issue no request.
  - Misaligned memory op (half with addr[0]; word with addr[1:0]≠0): no request; wb_excp_o=1, wb_excp_num_o=ALE_CODE, wb_wreg_o=0.
  - Aligned memory op: latch the op and go to REQ.
- REQ:
  - data_req_o=1; address, we, wstrb and wdata stay stable until data_addr_ok_i.
  - On addr_ok go to WAIT.
- WAIT:
  - On data_data_ok_i, register the wb outputs and go to IDLE.
  - Stores complete with wb_wreg_o=0.
- Load data:
  - Byte lane = addr[1:0].
  - LD.B/LD.H sign-extend; LD.BU/LD.HU zero-extend; LD.W passes the word.
- Store encoding:
  - ST.B: wstrb=1<<addr[1:0], wdata={4{b}}.
  - ST.H: wstrb=4'b0011<<addr[1:0], wdata={2{h}}.
  - ST.W: wstrb=4'hF.
- stallreq_o=1 in REQ, WAIT and DRAIN.
- wb_valid_o is a one-cycle pulse per accepted instruction; it is 0 in every other cycle.
- Flush:
  - In REQ before addr_ok: drop the request the same cycle, go to IDLE.
  - In REQ coincident with addr_ok: go to DRAIN.
  - In WAIT: go to DRAIN, or to IDLE if data_ok arrives in the same cycle.
  - DRAIN discards the returning data_ok, then goes to IDLE.
  - No wb_valid_o for any flushed op.
- Single outstanding request only; no new request is issued in DRAIN.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined: PERF_W-bit outputs perf_ld_cnt_o, perf_st_cnt_o and perf_stall_cyc_o are added.
  - Load and store counts increment on completion.
  - Stall counter increments every cycle stallreq_o=1.
  - All three clear on reset and wrap at max.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines:
  - EXE_LD_B/H/W/BU/HU_OP and EXE_ST_B/H/W_OP codes.
  - EXCP_ALE constant.
  - LSU state encodings.
- One combinational sub-module, lsu_align: store strobe/data generation, load extract/extend, and misalignment detect.

Test Plan:
- LD.B addr 0x1003, rdata 0x80AB_CDEF, addr_ok and data_ok each one cycle later -> data_addr_o=0x1000, wb_wdata_o=0xFFFF_FF80, stallreq high 2 cycles.
- ST.H addr 0x2002, reg2 0x1234_5678 -> wstrb=4'b1100, wdata=0x5678_5678; on data_ok wb_valid_o=1, wb_wreg_o=0.
- LD.W addr 0x3001 -> no data_req_o; next cycle wb_excp_o=1, wb_excp_num_o=0x009.
- LD.HU addr 0x4002 with addr_ok delayed 3 cycles, then flush_i in WAIT -> data_ok discarded, no wb_valid_o, stallreq drops the cycle after data_ok.
- EXE_ADD result 0x55 back-to-back with a load -> ADD written back 1 cycle after accept; load accepted next cycle.
- Assert rst in WAIT -> all outputs zero immediately; later stray data_ok ignored.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared op codes, exception numbers and LSU state encoding for the memory stage.
package mem_lsu_pkg;

    localparam logic [7:0] EXE_ADD_OP   = 8'h01;
    localparam logic [7:0] EXE_LD_B_OP  = 8'h10;
    localparam logic [7:0] EXE_LD_H_OP  = 8'h11;
    localparam logic [7:0] EXE_LD_W_OP  = 8'h12;
    localparam logic [7:0] EXE_LD_BU_OP = 8'h13;
    localparam logic [7:0] EXE_LD_HU_OP = 8'h14;
    localparam logic [7:0] EXE_ST_B_OP  = 8'h18;
    localparam logic [7:0] EXE_ST_H_OP  = 8'h19;
    localparam logic [7:0] EXE_ST_W_OP  = 8'h1A;

    localparam logic [9:0] EXCP_ALE = 10'h009;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } lsu_state_t;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {EXE_LD_B_OP, EXE_LD_H_OP, EXE_LD_W_OP, EXE_LD_BU_OP, EXE_LD_HU_OP};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {EXE_ST_B_OP, EXE_ST_H_OP, EXE_ST_W_OP};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes/replicated data, load extract/extend, misalignment detect.
// Purely combinational; no backpressure.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  i_chk_op,
    input  logic [1:0]  i_chk_addr,
    output logic        o_misalign,
    input  logic [7:0]  i_op,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_sh;

    // Shift the addressed lane down to bit 0; halves land in [15:0].
    assign w_sh = i_rdata >> {i_addr, 3'b000};

    always_comb begin
        o_misalign = 1'b0;
        case (i_chk_op)
            EXE_LD_H_OP, EXE_LD_HU_OP, EXE_ST_H_OP: o_misalign = i_chk_addr[0];
            EXE_LD_W_OP, EXE_ST_W_OP:               o_misalign = |i_chk_addr;
            default:                                o_misalign = 1'b0;
        endcase
    end

    always_comb begin
        o_ld_data = i_rdata;
        case (i_op)
            EXE_LD_B_OP:  o_ld_data = {{24{w_sh[7]}}, w_sh[7:0]};
            EXE_LD_BU_OP: o_ld_data = {24'h0, w_sh[7:0]};
            EXE_LD_H_OP:  o_ld_data = {{16{w_sh[15]}}, w_sh[15:0]};
            EXE_LD_HU_OP: o_ld_data = {16'h0, w_sh[15:0]};
            default:      o_ld_data = i_rdata;
        endcase
    end

    always_comb begin
        o_wstrb = 4'h0;
        o_wdata = 32'h0;
        case (i_op)
            EXE_ST_B_OP: begin
                o_wstrb = 4'b0001 << i_addr;
                o_wdata = {4{i_st_data[7:0]}};
            end
            EXE_ST_H_OP: begin
                o_wstrb = 4'b0011 << i_addr;
                o_wdata = {2{i_st_data[15:0]}};
            end
            EXE_ST_W_OP: begin
                o_wstrb = 4'hF;
                o_wdata = i_st_data;
            end
            default: begin
                o_wstrb = 4'h0;
                o_wdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage: one outstanding req/addr_ok/data_ok access per load/store; other ops pass through.
// Latency: 1 cycle for pass-through/faulting ops, 1 cycle after data_ok for memory ops.
// Backpressure: stallreq_o high in REQ/WAIT/DRAIN. Optional counters via LSU_PERF_CNT_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
`ifdef LSU_PERF_CNT_EN
    parameter int          PERF_W   = 32,
`endif
    parameter logic [9:0]  ALE_CODE = EXCP_ALE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        ex_valid_i,
    input  logic [7:0]  ex_aluop_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [31:0] ex_reg2_i,
    input  logic [4:0]  ex_wd_i,
    input  logic        ex_wreg_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        ex_excp_i,
    input  logic [9:0]  ex_excp_num_i,
    output logic        stallreq_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_wstrb_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
`ifdef LSU_PERF_CNT_EN
    output logic [PERF_W-1:0] perf_ld_cnt_o,
    output logic [PERF_W-1:0] perf_st_cnt_o,
    output logic [PERF_W-1:0] perf_stall_cyc_o,
`endif
    output logic        wb_valid_o,
    output logic [4:0]  wb_wd_o,
    output logic        wb_wreg_o,
    output logic [31:0] wb_wdata_o,
    output logic        wb_excp_o,
    output logic [9:0]  wb_excp_num_o
);

    lsu_state_t  r_state;
    logic [7:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_reg2;
    logic [4:0]  r_wd;
    logic        r_wreg;
    logic        r_wb_valid;
    logic [4:0]  r_wb_wd;
    logic        r_wb_wreg;
    logic [31:0] r_wb_wdata;
    logic        r_wb_excp;
    logic [9:0]  r_wb_excp_num;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_misalign;
    logic        w_in_req;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;

    assign w_accept = ex_valid_i && !flush_i;
    assign w_is_mem = is_load(ex_aluop_i) || is_store(ex_aluop_i);
    assign w_in_req = (r_state == S_REQ);

    lsu_align u_align (
        .i_chk_op   (ex_aluop_i),
        .i_chk_addr (ex_mem_addr_i[1:0]),
        .o_misalign (w_misalign),
        .i_op       (r_op),
        .i_addr     (r_addr[1:0]),
        .i_st_data  (r_reg2),
        .i_rdata    (data_rdata_i),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_ld_data  (w_ld_data)
    );

    assign stallreq_o    = (r_state != S_IDLE);
    assign data_req_o    = w_in_req;
    assign data_we_o     = w_in_req && is_store(r_op);
    assign data_addr_o   = {r_addr[31:2], 2'b00};
    assign data_wstrb_o  = w_in_req ? w_wstrb : 4'h0;
    assign data_wdata_o  = w_wdata;
    assign wb_valid_o    = r_wb_valid;
    assign wb_wd_o       = r_wb_wd;
    assign wb_wreg_o     = r_wb_wreg;
    assign wb_wdata_o    = r_wb_wdata;
    assign wb_excp_o     = r_wb_excp;
    assign wb_excp_num_o = r_wb_excp_num;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_op          <= 8'h0;
            r_addr        <= 32'h0;
            r_reg2        <= 32'h0;
            r_wd          <= 5'h0;
            r_wreg        <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_wd       <= 5'h0;
            r_wb_wreg     <= 1'b0;
            r_wb_wdata    <= 32'h0;
            r_wb_excp     <= 1'b0;
            r_wb_excp_num <= 10'h0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (ex_excp_i || !w_is_mem) begin
                            r_wb_valid    <= 1'b1;
                            r_wb_wd       <= ex_wd_i;
                            r_wb_wreg     <= ex_wreg_i;
                            r_wb_wdata    <= ex_wdata_i;
                            r_wb_excp     <= ex_excp_i;
                            r_wb_excp_num <= ex_excp_num_i;
                        end else if (w_misalign) begin
                            r_wb_valid    <= 1'b1;
                            r_wb_wd       <= ex_wd_i;
                            r_wb_wreg     <= 1'b0;
                            r_wb_wdata    <= ex_wdata_i;
                            r_wb_excp     <= 1'b1;
                            r_wb_excp_num <= ALE_CODE;
                        end else begin
                            r_op    <= ex_aluop_i;
                            r_addr  <= ex_mem_addr_i;
                            r_reg2  <= ex_reg2_i;
                            r_wd    <= ex_wd_i;
                            r_wreg  <= ex_wreg_i;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A flush that races the bus accept still owes us a data_ok.
                    if (data_addr_ok_i) begin
                        r_state <= flush_i ? S_DRAIN : S_WAIT;
                    end else if (flush_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok_i) begin
                        r_state <= S_IDLE;
                        if (!flush_i) begin
                            r_wb_valid    <= 1'b1;
                            r_wb_wd       <= r_wd;
                            r_wb_wreg     <= r_wreg && is_load(r_op);
                            r_wb_wdata    <= is_store(r_op) ? 32'h0 : w_ld_data;
                            r_wb_excp     <= 1'b0;
                            r_wb_excp_num <= 10'h0;
                        end
                    end else if (flush_i) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (data_data_ok_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    logic              w_done;
    logic [PERF_W-1:0] r_ld_cnt;
    logic [PERF_W-1:0] r_st_cnt;
    logic [PERF_W-1:0] r_stall_cyc;

    assign w_done = (r_state == S_WAIT) && data_data_ok_i && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_cnt    <= '0;
            r_st_cnt    <= '0;
            r_stall_cyc <= '0;
        end else begin
            if (w_done && is_load(r_op)) begin
                r_ld_cnt <= r_ld_cnt + 1'b1;
            end
            if (w_done && is_store(r_op)) begin
                r_st_cnt <= r_st_cnt + 1'b1;
            end
            if (stallreq_o) begin
                r_stall_cyc <= r_stall_cyc + 1'b1;
            end
        end
    end

    assign perf_ld_cnt_o    = r_ld_cnt;
    assign perf_st_cnt_o    = r_st_cnt;
    assign perf_stall_cyc_o = r_stall_cyc;
`endif

endmodule
